// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bus of the register-file write arbiter: three writeback
// sources sharing one valid/ready handshake bundle.
interface regfile_write_arbiter_if;
    // Handshake: requester i raises req_valid[i] and holds req_lock[i],
    // req_addr<i> and req_data<i> stable until it sees req_ready[i] high at a
    // rising clock edge; that edge is the transfer. req_ready is one-hot or
    // zero, never set where req_valid is low, and never depends on addr/data.
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [2:0]  req_ready;
    logic [4:0]  req_addr0;
    logic [4:0]  req_addr1;
    logic [4:0]  req_addr2;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic [31:0] req_data2;

    modport master (
        output req_valid, req_lock, req_addr0, req_addr1, req_addr2,
               req_data0, req_data1, req_data2,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_lock, req_addr0, req_addr1, req_addr2,
               req_data0, req_data1, req_data2,
        output req_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with bounded burst lock for the single register-file
// write port; the write port itself is driven from registers.
module regfile_write_arbiter #(
    parameter int MAX_BURST    = 4,
    parameter bit ZERO_PROTECT = 1'b0
) (
    input  logic                    new_clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  req,
    output logic                    reg_write,
    output logic [4:0]              add_write,
    output logic [31:0]             data_write,
    output logic [1:0]              grant_id,
    output logic [15:0]             collision_cnt,
    output logic                    dbg_state,
    output logic [1:0]              dbg_ptr,
    output logic [1:0]              dbg_owner,
    output logic [3:0]              dbg_burst_cnt
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    logic [0:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  add_write_q, add_write_d;
    logic [31:0] data_write_q, data_write_d;
    logic [1:0]  grant_id_q, grant_id_d;
    logic [15:0] collision_cnt_q, collision_cnt_d;

    logic [2:0]  ready;
    logic [1:0]  win;
    logic        xfer;
    logic [2:0]  sum;
    logic [1:0]  cand;
    logic [4:0]  win_addr;
    logic [31:0] win_data;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Winner selection looks only at valid, lock state and pointer.
    always_comb begin
        ready = '0;
        win   = '0;
        xfer  = 1'b0;
        sum   = '0;
        cand  = '0;
        if (state_q == ST_IDLE) begin
            for (int k = 0; k < 3; k++) begin
                sum  = {1'b0, ptr_q} + 3'(k);
                cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                if (!xfer && req.req_valid[cand]) begin
                    xfer = 1'b1;
                    win  = cand;
                end
            end
        end else if (req.req_valid[owner_q]) begin
            xfer = 1'b1;
            win  = owner_q;
        end
        if (xfer) ready[win] = 1'b1;
    end

    assign req.req_ready = ready;

    always_comb begin
        win_addr = req.req_addr0;
        win_data = req.req_data0;
        case (win)
            2'd1:    begin win_addr = req.req_addr1; win_data = req.req_data1; end
            2'd2:    begin win_addr = req.req_addr2; win_data = req.req_data2; end
            default: begin win_addr = req.req_addr0; win_data = req.req_data0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == ST_IDLE) begin
            if (xfer) begin
                // A one-grant burst is no lock at all, so MAX_BURST=1 never enters LOCKED.
                if (req.req_lock[win] && (MAX_BURST > 1)) begin
                    state_d     = ST_LOCKED;
                    owner_d     = win;
                    burst_cnt_d = 4'd1;
                end else begin
                    ptr_d = inc3(win);
                end
            end
        end else begin
            if (!xfer || !req.req_lock[owner_q] || (burst_cnt_q >= BURST_LAST)) begin
                state_d     = ST_IDLE;
                ptr_d       = inc3(owner_q);
                burst_cnt_d = 4'd0;
            end else begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        reg_write_d     = xfer && !(ZERO_PROTECT && (win_addr == 5'd0));
        add_write_d     = xfer ? win_addr : add_write_q;
        data_write_d    = xfer ? win_data : data_write_q;
        grant_id_d      = xfer ? win : 2'b11;
        collision_cnt_d = collision_cnt_q;
        if (((req.req_valid[0] & req.req_valid[1]) | (req.req_valid[0] & req.req_valid[2]) |
             (req.req_valid[1] & req.req_valid[2])) && (collision_cnt_q != 16'hFFFF))
            collision_cnt_d = collision_cnt_q + 16'd1;
    end

    always_ff @(posedge new_clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ptr_q           <= 2'd0;
            owner_q         <= 2'd0;
            burst_cnt_q     <= 4'd0;
            reg_write_q     <= 1'b0;
            add_write_q     <= 5'd0;
            data_write_q    <= 32'd0;
            grant_id_q      <= 2'b11;
            collision_cnt_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            owner_q         <= owner_d;
            burst_cnt_q     <= burst_cnt_d;
            reg_write_q     <= reg_write_d;
            add_write_q     <= add_write_d;
            data_write_q    <= data_write_d;
            grant_id_q      <= grant_id_d;
            collision_cnt_q <= collision_cnt_d;
        end
    end

    assign reg_write     = reg_write_q;
    assign add_write     = add_write_q;
    assign data_write    = data_write_q;
    assign grant_id      = grant_id_q;
    assign collision_cnt = collision_cnt_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;
    assign dbg_owner     = owner_q;
    assign dbg_burst_cnt = burst_cnt_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a burst-4 zero-protected instance
// and a burst-1 unprotected instance see the same requester traffic.
module tb_regfile_write_arbiter;
    logic new_clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    logic [1:0] exp_q[$];

    regfile_write_arbiter_if ia ();
    regfile_write_arbiter_if ib ();

    logic        a_reg_write, b_reg_write;
    logic [4:0]  a_add_write, b_add_write;
    logic [31:0] a_data_write, b_data_write;
    logic [1:0]  a_grant_id, b_grant_id;
    logic [15:0] a_collision_cnt, b_collision_cnt;
    logic        a_state, b_state;
    logic [1:0]  a_ptr, b_ptr, a_owner, b_owner;
    logic [3:0]  a_burst, b_burst;

    assign ib.req_valid = ia.req_valid;
    assign ib.req_lock  = ia.req_lock;
    assign ib.req_addr0 = ia.req_addr0;
    assign ib.req_addr1 = ia.req_addr1;
    assign ib.req_addr2 = ia.req_addr2;
    assign ib.req_data0 = ia.req_data0;
    assign ib.req_data1 = ia.req_data1;
    assign ib.req_data2 = ia.req_data2;

    regfile_write_arbiter #(.MAX_BURST(4), .ZERO_PROTECT(1'b1)) u_dut_a (
        .new_clk(new_clk), .reset(reset), .req(ia.slave),
        .reg_write(a_reg_write), .add_write(a_add_write), .data_write(a_data_write),
        .grant_id(a_grant_id), .collision_cnt(a_collision_cnt),
        .dbg_state(a_state), .dbg_ptr(a_ptr), .dbg_owner(a_owner), .dbg_burst_cnt(a_burst)
    );

    regfile_write_arbiter #(.MAX_BURST(1), .ZERO_PROTECT(1'b0)) u_dut_b (
        .new_clk(new_clk), .reset(reset), .req(ib.slave),
        .reg_write(b_reg_write), .add_write(b_add_write), .data_write(b_data_write),
        .grant_id(b_grant_id), .collision_cnt(b_collision_cnt),
        .dbg_state(b_state), .dbg_ptr(b_ptr), .dbg_owner(b_owner), .dbg_burst_cnt(b_burst)
    );

    // Clock and reset
    initial begin
        new_clk = 1'b0;
        forever #5 new_clk = ~new_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge only
    task automatic drive(input logic [2:0] valid, input logic [2:0] lock);
        ia.req_valid = valid;
        ia.req_lock  = lock;
    endtask

    task automatic set_payload(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        ia.req_addr0 = a0; ia.req_addr1 = a1; ia.req_addr2 = a2;
        ia.req_data0 = d0; ia.req_data1 = d1; ia.req_data2 = d2;
    endtask

    task automatic next_cycle();
        @(negedge new_clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] e;
        logic [1:0] a_exp [5];
        logic [1:0] b_exp [5];
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        drive(3'b000, 3'b000);
        set_payload(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        check("rst_reg_write", 32'(a_reg_write), 32'd0);
        check("rst_grant_id", 32'(a_grant_id), 32'd3);
        check("rst_add_write", 32'(a_add_write), 32'd0);
        check("rst_data_write", a_data_write, 32'd0);
        check("rst_collision", 32'(a_collision_cnt), 32'd0);
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_ptr", 32'(a_ptr), 32'd0);
        reset = 1'b0;
        next_cycle();

        // Single requester 1, addr 5, data 0x1234
        set_payload(5'd0, 5'd5, 5'd0, 32'd0, 32'h1234, 32'd0);
        drive(3'b010, 3'b000);
        #1 check("single_ready", 32'(ia.req_ready), 32'b010);
        next_cycle();
        drive(3'b000, 3'b000);
        check("single_reg_write", 32'(a_reg_write), 32'd1);
        check("single_add_write", 32'(a_add_write), 32'd5);
        check("single_data_write", a_data_write, 32'h1234);
        check("single_grant_id", 32'(a_grant_id), 32'd1);
        check("single_ptr", 32'(a_ptr), 32'd2);
        #1 check("idle_ready", 32'(ia.req_ready), 32'd0);
        next_cycle();
        check("idle_grant_id", 32'(a_grant_id), 32'd3);
        check("idle_reg_write", 32'(a_reg_write), 32'd0);
        check("idle_add_hold", 32'(a_add_write), 32'd5);

        // Plain round-robin with all three valid
        do_reset();
        set_payload(5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
        for (int i = 0; i < 6; i++) exp_q.push_back(2'(i % 3));
        drive(3'b111, 3'b000);
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            #1 check("rr_ready", 32'(ia.req_ready), 32'(3'b001 << e));
            next_cycle();
            check("rr_grant_a", 32'(a_grant_id), 32'(e));
            check("rr_grant_b", 32'(b_grant_id), 32'(e));
            check("rr_add_write", 32'(a_add_write), 32'(e) + 32'd1);
            check("rr_data_write", a_data_write, 32'hA0 + 32'(e));
        end
        drive(3'b000, 3'b000);
        check("rr_collision", 32'(a_collision_cnt), 32'd6);
        check("rr_ptr", 32'(a_ptr), 32'd0);

        // Burst lock on requester 0 while requester 2 waits
        a_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
        b_exp = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        drive(3'b101, 3'b001);
        for (int i = 0; i < 5; i++) begin
            #1 check("lock_ready", 32'(ia.req_ready), 32'(3'b001 << a_exp[i]));
            next_cycle();
            check("lock_grant_a", 32'(a_grant_id), 32'(a_exp[i]));
            check("lock_grant_b", 32'(b_grant_id), 32'(b_exp[i]));
            if (i == 0) check("lock_state_entered", 32'(a_state), 32'd1);
            if (i == 3) check("lock_ptr_after_burst", 32'(a_ptr), 32'd1);
        end
        check("lock_state_exit", 32'(a_state), 32'd0);
        check("lock_ptr_final", 32'(a_ptr), 32'd0);
        check("lock_b_never_locks", 32'(b_state), 32'd0);

        // Owner drops valid while locked: no grant, pointer moves past owner
        drive(3'b001, 3'b001);
        next_cycle();
        check("drop_locked", 32'(a_state), 32'd1);
        drive(3'b010, 3'b000);
        #1 check("drop_ready_blocked", 32'(ia.req_ready), 32'd0);
        next_cycle();
        check("drop_grant_none", 32'(a_grant_id), 32'd3);
        check("drop_state", 32'(a_state), 32'd0);
        check("drop_ptr", 32'(a_ptr), 32'd1);
        #1 check("drop_ready_after", 32'(ia.req_ready), 32'b010);
        next_cycle();
        check("drop_grant_1", 32'(a_grant_id), 32'd1);

        // Address 0 write: handshake completes, protected instance suppresses write
        set_payload(5'd1, 5'd2, 5'd0, 32'hA0, 32'hA1, 32'hDEAD);
        drive(3'b100, 3'b000);
        #1 check("zp_ready", 32'(ia.req_ready), 32'b100);
        next_cycle();
        drive(3'b000, 3'b000);
        check("zp_grant_id", 32'(a_grant_id), 32'd2);
        check("zp_reg_write_a", 32'(a_reg_write), 32'd0);
        check("zp_reg_write_b", 32'(b_reg_write), 32'd1);
        check("zp_add_write", 32'(a_add_write), 32'd0);

        // Reset in the cycle after a locked transfer
        set_payload(5'd7, 5'd2, 5'd3, 32'h77, 32'hA1, 32'hA2);
        drive(3'b011, 3'b001);
        next_cycle();
        drive(3'b000, 3'b000);
        check("mid_reg_write_pre", 32'(a_reg_write), 32'd1);
        check("mid_state_pre", 32'(a_state), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reg_write", 32'(a_reg_write), 32'd0);
        check("mid_state", 32'(a_state), 32'd0);
        check("mid_collision", 32'(a_collision_cnt), 32'd0);
        check("mid_grant_id", 32'(a_grant_id), 32'd3);
        next_cycle();
        reset = 1'b0;

        // Collision counter saturation
        drive(3'b111, 3'b000);
        repeat (65534) next_cycle();
        check("sat_before", 32'(a_collision_cnt), 32'hFFFE);
        repeat (4466) next_cycle();
        check("sat_hold", 32'(a_collision_cnt), 32'hFFFF);
        drive(3'b000, 3'b000);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
